// File: rtl/sonar_pkg.sv
// Shared types and default timing for the sonar ranging scheduler.
package sonar_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLDOFF
  } state_t;

  localparam int CLK_HZ              = 100_000_000;
  localparam int DEF_TRIG_CYCLES     = 1000;
  localparam int DEF_RISE_TIMEOUT    = 100_000;
  localparam int DEF_MAX_ECHO        = 3_800_000;
  localparam int DEF_HOLDOFF_CYCLES  = 6_000_000;
  localparam int DEF_CRASH_THRESH    = 294_117;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sonar_scheduler_echo_sync.sv
// Two-flop synchronizer for the asynchronous echo lines.
module echo_sync #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_echo,
  output logic [N-1:0] o_echo_s
);

  logic [N-1:0] r_meta;
  logic [N-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_echo;
      r_sync <= r_meta;
    end
  end

  assign o_echo_s = r_sync;

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin ultrasonic ranging scheduler: one ping at a time, echo width
// measurement, timeout detection and latched per-sensor crash flags.
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter int NUM_SENSORS    = 3,
  parameter int DIST_W         = 22,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int RISE_TIMEOUT   = DEF_RISE_TIMEOUT,
  parameter int MAX_ECHO       = DEF_MAX_ECHO,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int CRASH_THRESH   = DEF_CRASH_THRESH,
  localparam int SEL_W         = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trigger,
  output logic                   dist_valid,
  output logic [SEL_W-1:0]       dist_id,
  output logic [DIST_W-1:0]      dist_cycles,
  output logic                   dist_timeout,
  output logic [NUM_SENSORS-1:0] is_crash,
  output logic                   is_crash_any
);

  // The default holdoff does not fit in DIST_W bits, so the shared counter
  // widens as needed; results only ever use the low DIST_W bits.
  localparam int CNT_W = max_int(DIST_W, max_int($clog2(HOLDOFF_CYCLES + 1),
                         max_int($clog2(RISE_TIMEOUT + 1), $clog2(TRIG_CYCLES + 1))));

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ECHO_LIM  = CNT_W'(MAX_ECHO);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CRASH_LIM = CNT_W'(CRASH_THRESH);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_SENSORS - 1);

  state_t                 r_state;
  logic [SEL_W-1:0]       r_sel;
  logic [CNT_W-1:0]       r_cnt;
  logic [NUM_SENSORS-1:0] r_trigger;
  logic                   r_valid;
  logic                   r_timeout;
  logic [SEL_W-1:0]       r_id;
  logic [DIST_W-1:0]      r_cycles;
  logic [NUM_SENSORS-1:0] r_crash;

  logic [NUM_SENSORS-1:0] w_echo_s;
  logic [NUM_SENSORS-1:0] w_sel_oh;
  logic                   w_echo;

  echo_sync #(.N(NUM_SENSORS)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_echo   (echo),
    .o_echo_s (w_echo_s)
  );

  always_comb begin
    w_sel_oh = '0;
    for (int i = 0; i < NUM_SENSORS; i++) w_sel_oh[i] = (r_sel == SEL_W'(i));
  end

  // Only the selected sensor's echo is ever observed.
  assign w_echo = |(w_echo_s & w_sel_oh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_trigger <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_id      <= '0;
      r_cycles  <= '0;
      r_crash   <= '0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state   <= S_TRIG;
            r_trigger <= w_sel_oh;
            r_cnt     <= '0;
          end
        end
        S_TRIG: begin
          if (r_cnt == TRIG_LAST) begin
            r_state   <= S_WAIT_RISE;
            r_trigger <= '0;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT_RISE: begin
          // A line already high counts as a rise; MEASURE then bounds it.
          if (w_echo) begin
            r_state <= S_MEASURE;
            r_cnt   <= CNT_W'(1);
          end else if (r_cnt == RISE_LAST) begin
            r_state   <= S_HOLDOFF;
            r_cnt     <= '0;
            r_valid   <= 1'b1;
            r_timeout <= 1'b1;
            r_id      <= r_sel;
            r_cycles  <= '0;
            r_crash   <= r_crash & ~w_sel_oh;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_MEASURE: begin
          if (!w_echo) begin
            r_state  <= S_HOLDOFF;
            r_cnt    <= '0;
            r_valid  <= 1'b1;
            r_id     <= r_sel;
            r_cycles <= r_cnt[DIST_W-1:0];
            r_crash  <= (r_crash & ~w_sel_oh) | ((r_cnt <= CRASH_LIM) ? w_sel_oh : '0);
          end else if (r_cnt == ECHO_LIM) begin
            r_state   <= S_HOLDOFF;
            r_cnt     <= '0;
            r_valid   <= 1'b1;
            r_timeout <= 1'b1;
            r_id      <= r_sel;
            r_cycles  <= '0;
            r_crash   <= r_crash & ~w_sel_oh;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_HOLDOFF: begin
          if (r_cnt == HOLD_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sel   <= (r_sel == SEL_LAST) ? '0 : r_sel + SEL_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_trigger <= '0;
        end
      endcase
    end
  end

  assign trigger      = r_trigger;
  assign dist_valid   = r_valid;
  assign dist_id      = r_id;
  assign dist_cycles  = r_cycles;
  assign dist_timeout = r_timeout;
  assign is_crash     = r_crash;
  assign is_crash_any = |r_crash;

endmodule
